// File: rtl/bmp_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bmp_loader_pkg                                                   |
// | Brief   : Shared types, error codes and BMP header offsets for bmp_loader. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bmp_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_PIXELS = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_SIG   = 3'd1;
  localparam logic [2:0] ERR_OFS   = 3'd2;
  localparam logic [2:0] ERR_BPP   = 3'd3;
  localparam logic [2:0] ERR_SIZE  = 3'd4;
  localparam logic [2:0] ERR_OVF   = 3'd5;
  localparam logic [2:0] ERR_TRUNC = 3'd6;

  // Byte offsets of the little-endian header fields inside the file
  localparam logic [24:0] HDR_SIG = 25'd0;
  localparam logic [24:0] HDR_OFS = 25'd10;
  localparam logic [24:0] HDR_WID = 25'd18;
  localparam logic [24:0] HDR_HGT = 25'd22;
  localparam logic [24:0] HDR_BPP = 25'd28;
  localparam logic [24:0] HDR_END = 25'd29;

  // Byte-lane enables {hi,lo} for a byte address: odd bytes go to the high lane
  function automatic logic [1:0] lane_enable(input logic lsb);
    return {lsb, ~lsb};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bmp_wr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bmp_wr_fifo                                                      |
// | Brief   : Synchronous FIFO holding {relative address, byte} pixel writes.  |
// |           Push on a full FIFO is accepted only when a pop happens in the  |
// |           same cycle.                                                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bmp_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array; no reset needed since occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue at once
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bmp_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bmp_loader                                                       |
// | Brief   : Parses a streamed 32bpp BMP, validates its header and turns its |
// |           pixel bytes into byte-lane SDRAM writes over a req/ack toggle    |
// |           handshake.                                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bmp_loader
  import bmp_loader_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_WIDTH  = 512,
  parameter int MAX_HEIGHT = 312,
  parameter int BPP_REQ    = 32
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        bmp_loaded,
  output logic [2:0]  bmp_error,
  output logic [9:0]  bmp_width,
  output logic [8:0]  bmp_height
);

  localparam logic [31:0] MAX_W     = 32'(MAX_WIDTH);
  localparam logic [31:0] MAX_H     = 32'(MAX_HEIGHT);
  localparam logic [15:0] BPP_W     = 16'(BPP_REQ);
  localparam logic [24:0] PIX_LIMIT = 25'(MAX_WIDTH * MAX_HEIGHT * 4);

  // Input edge detection and one-stage byte capture
  logic        wr_q;
  logic        dl_q;
  logic        acc_q;
  logic [24:0] addr_q;
  logic [7:0]  byte_q;
  logic        accept;
  logic        dl_rise;
  logic        dl_fall;

  // Header fields
  logic [23:0] ofs_q;
  logic [31:0] width_q;
  logic [31:0] height_q;
  logic [7:0]  bpp_lo_q;

  // Control
  state_e      state_q;
  state_e      state_d;
  logic [2:0]  err_q;
  logic [2:0]  err_d;
  logic        push;
  logic        pop;
  logic        flush;
  logic        size_bad;
  logic [24:0] rel_full;
  logic        pix_hit;

  // Write FIFO
  logic [31:0] fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;

  // Drain side registers
  logic        req_q;
  logic [22:0] a_q;
  logic [1:0]  ds_q;
  logic [15:0] d_q;

  assign accept  = ioctl_wr && !wr_q && ioctl_download;
  assign dl_rise = ioctl_download && !dl_q;
  assign dl_fall = !ioctl_download && dl_q;

  // Latch strobe/download history and register each accepted byte for one cycle
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_q   <= 1'b0;
      dl_q   <= 1'b0;
      acc_q  <= 1'b0;
      addr_q <= '0;
      byte_q <= '0;
    end else begin
      wr_q  <= ioctl_wr;
      dl_q  <= ioctl_download;
      acc_q <= accept;
      if (accept) begin
        addr_q <= ioctl_addr;
        byte_q <= ioctl_dout;
      end
    end
  end

  // Capture the little-endian header fields as their bytes stream past
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ofs_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      bpp_lo_q <= '0;
    end else if (acc_q && state_q == S_HEADER) begin
      case (addr_q)
        HDR_OFS:          ofs_q[7:0]      <= byte_q;
        HDR_OFS + 25'd1:  ofs_q[15:8]     <= byte_q;
        HDR_OFS + 25'd2:  ofs_q[23:16]    <= byte_q;
        HDR_WID:          width_q[7:0]    <= byte_q;
        HDR_WID + 25'd1:  width_q[15:8]   <= byte_q;
        HDR_WID + 25'd2:  width_q[23:16]  <= byte_q;
        HDR_WID + 25'd3:  width_q[31:24]  <= byte_q;
        HDR_HGT:          height_q[7:0]   <= byte_q;
        HDR_HGT + 25'd1:  height_q[15:8]  <= byte_q;
        HDR_HGT + 25'd2:  height_q[23:16] <= byte_q;
        HDR_HGT + 25'd3:  height_q[31:24] <= byte_q;
        HDR_BPP:          bpp_lo_q        <= byte_q;
        default: ;
      endcase
    end
  end

  // Unsigned compares also reject negative (top-down) heights
  assign size_bad = (width_q == '0) || (width_q > MAX_W) ||
                    (height_q == '0) || (height_q > MAX_H);
  assign rel_full = addr_q - {1'b0, ofs_q};
  assign pix_hit  = (addr_q >= {1'b0, ofs_q}) && (rel_full < PIX_LIMIT);

  // Flush on a new download and continuously while parked in ERROR
  assign flush = dl_rise || (state_q == S_ERROR);
  assign pop   = (req_q == port1_ack) && !fifo_empty && !flush;

  // State and error-code registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next-state: header validation, pixel routing, download start/end handling
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    push    = 1'b0;
    case (state_q)
      S_HEADER: begin
        if (acc_q) begin
          if ((addr_q == HDR_SIG && byte_q != 8'h42) ||
              (addr_q == HDR_SIG + 25'd1 && byte_q != 8'h4D)) begin
            state_d = S_ERROR;
            err_d   = ERR_SIG;
          end else if (addr_q == HDR_OFS + 25'd3 &&
                       (byte_q != 8'h00 || ofs_q < 24'd30)) begin
            state_d = S_ERROR;
            err_d   = ERR_OFS;
          end else if (addr_q == HDR_END) begin
            if ({byte_q, bpp_lo_q} != BPP_W) begin
              state_d = S_ERROR;
              err_d   = ERR_BPP;
            end else if (size_bad) begin
              state_d = S_ERROR;
              err_d   = ERR_SIZE;
            end else begin
              state_d = S_PIXELS;
            end
          end
        end
        // A byte accepted just before the fall is still processed first
        if (dl_fall) begin
          if (state_d == S_HEADER) begin
            state_d = S_ERROR;
            err_d   = ERR_TRUNC;
          end else if (state_d == S_PIXELS) begin
            state_d = S_DONE;
          end
        end
      end
      S_PIXELS: begin
        if (acc_q && pix_hit) begin
          if (fifo_full && !pop) begin
            state_d = S_ERROR;
            err_d   = ERR_OVF;
          end else begin
            push = 1'b1;
          end
        end
        if (dl_fall && state_d == S_PIXELS) begin
          state_d = S_DONE;
        end
      end
      default: ;
    endcase
    if (dl_rise) begin
      state_d = S_HEADER;
      err_d   = ERR_NONE;
      push    = 1'b0;
    end
  end

  bmp_wr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk_sys),
    .rst     (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({rel_full[23:0], byte_q}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Issue one SDRAM write per pop; req follows ack on reset so nothing is pending
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      req_q <= port1_ack;
      a_q   <= '0;
      ds_q  <= '0;
      d_q   <= '0;
    end else if (pop) begin
      req_q <= ~req_q;
      a_q   <= fifo_rdata[31:9];
      ds_q  <= lane_enable(fifo_rdata[8]);
      d_q   <= {fifo_rdata[7:0], fifo_rdata[7:0]};
    end
  end

  assign port1_req  = req_q;
  assign port1_a    = a_q;
  assign port1_ds   = ds_q;
  assign port1_d    = d_q;
  assign port1_we   = (state_q == S_PIXELS) || !fifo_empty;
  assign bmp_loaded = (state_q == S_DONE);
  assign bmp_error  = err_q;
  assign bmp_width  = width_q[9:0];
  assign bmp_height = height_q[8:0];

endmodule
`default_nettype wire

// File: tb/tb_bmp_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bmp_loader                                                    |
// | Brief   : Self-checking bench for bmp_loader against a file-level model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bmp_loader;

  localparam int DEPTH      = 4;
  localparam int MAX_WIDTH  = 512;
  localparam int MAX_HEIGHT = 312;
  localparam int BPP_REQ    = 32;
  localparam int LIMIT      = MAX_WIDTH * MAX_HEIGHT * 4;

  logic        clk_sys        = 1'b0;
  logic        reset          = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr       = 1'b0;
  logic [24:0] ioctl_addr     = '0;
  logic [7:0]  ioctl_dout     = '0;
  logic        port1_ack      = 1'b0;
  logic        port1_req;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port1_we;
  logic        bmp_loaded;
  logic [2:0]  bmp_error;
  logic [9:0]  bmp_width;
  logic [8:0]  bmp_height;

  bmp_loader #(
    .DEPTH(DEPTH), .MAX_WIDTH(MAX_WIDTH), .MAX_HEIGHT(MAX_HEIGHT), .BPP_REQ(BPP_REQ)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d), .port1_we(port1_we),
    .bmp_loaded(bmp_loaded), .bmp_error(bmp_error),
    .bmp_width(bmp_width), .bmp_height(bmp_height)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } req_t;

  int         checks = 0;
  int         errors = 0;
  req_t       got[$];
  logic [7:0] fbytes[$];
  int         ack_delay = 3;
  int         busy = 0;
  int         cnt = 0;
  int         hmin = 1, hmax = 3, lmin = 6, lmax = 8;

  // SDRAM model: record each new request, answer it ack_delay clocks later
  always @(negedge clk_sys) begin
    req_t r;
    if (reset) begin
      busy = 0;
    end else if (busy != 0) begin
      if (cnt <= 1) begin
        port1_ack = ~port1_ack;
        busy = 0;
      end else begin
        cnt = cnt - 1;
      end
    end else if (port1_req !== port1_ack) begin
      r.a = port1_a; r.ds = port1_ds; r.d = port1_d;
      got.push_back(r);
      busy = 1;
      cnt  = ack_delay;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get32(input int at);
    return {fbytes[at+3], fbytes[at+2], fbytes[at+1], fbytes[at]};
  endfunction

  task automatic put32(input int at, input logic [31:0] v);
    for (int k = 0; k < 4; k++) fbytes[at+k] = v[8*k +: 8];
  endtask

  // Assemble a BMP file image: header, zero gap up to the offset, random pixels
  task automatic build_file(input int npix, input logic [31:0] w, input logic [31:0] h,
                            input logic [15:0] bpp, input int ofs,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] ofs_hi);
    int hlen;
    hlen = (ofs > 30) ? ofs : 30;
    fbytes.delete();
    for (int i = 0; i < hlen; i++) fbytes.push_back(8'h00);
    fbytes[0] = s0;
    fbytes[1] = s1;
    put32(2, 32'(hlen + npix));
    put32(10, 32'(ofs));
    fbytes[13] = ofs_hi;
    put32(14, 32'd40);
    put32(18, w);
    put32(22, h);
    fbytes[26] = 8'd1;
    fbytes[28] = bpp[7:0];
    fbytes[29] = bpp[15:8];
    for (int i = 0; i < npix; i++) fbytes.push_back(8'($urandom));
  endtask

  // Header verdict for a complete file, straight from the format rules
  function automatic logic [2:0] exp_err();
    logic [31:0] ofs, w, h;
    ofs = get32(10); w = get32(18); h = get32(22);
    if (fbytes[0] != 8'h42 || fbytes[1] != 8'h4D) return 3'd1;
    if (ofs > 32'h00FF_FFFF || ofs < 32'd30) return 3'd2;
    if ({fbytes[29], fbytes[28]} != 16'(BPP_REQ)) return 3'd3;
    if (w == 0 || w > 32'(MAX_WIDTH) || h == 0 || h > 32'(MAX_HEIGHT)) return 3'd4;
    return 3'd0;
  endfunction

  task automatic send_file(input int first, input int last, input bit raise, input bit drop);
    int hi, lo;
    if (raise) begin
      @(negedge clk_sys);
      ioctl_download = 1'b1;
      repeat (3) @(negedge clk_sys);
    end
    for (int i = first; i <= last && i < fbytes.size(); i++) begin
      hi = $urandom_range(hmax, hmin);
      lo = $urandom_range(lmax, lmin);
      ioctl_addr = 25'(i);
      ioctl_dout = fbytes[i];
      ioctl_wr   = 1'b1;
      repeat (hi) @(negedge clk_sys);
      ioctl_wr = 1'b0;
      repeat (lo) @(negedge clk_sys);
    end
    if (drop) begin
      ioctl_download = 1'b0;
      repeat (2) @(negedge clk_sys);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (!(port1_we == 1'b0 && port1_req == port1_ack && busy == 0) && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    chk(tag, 64'(n < 3000), 64'd1);
  endtask

  // Expected write stream: every pixel byte in file order at its relative address
  task automatic check_stream(input string tag);
    req_t exp_q[$];
    req_t r;
    int   ofs, rel;
    ofs = int'(get32(10));
    for (int i = ofs; i < fbytes.size(); i++) begin
      rel = i - ofs;
      if (rel < LIMIT) begin
        r.a  = 23'(rel / 2);
        r.ds = (rel % 2 == 1) ? 2'b10 : 2'b01;
        r.d  = {fbytes[i], fbytes[i]};
        exp_q.push_back(r);
      end
    end
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int k = 0; k < got.size() && k < exp_q.size(); k++)
      chk({tag, "_req"}, 64'(got[k]), 64'(exp_q[k]));
  endtask

  initial begin
    int w, h, kind, ofs;
    logic [2:0] e;

    // Reset state
    repeat (3) @(negedge clk_sys);
    chk("rst_req_eq_ack", 64'(port1_req == port1_ack), 64'd1);
    chk("rst_a",      64'(port1_a),    64'd0);
    chk("rst_ds",     64'(port1_ds),   64'd0);
    chk("rst_d",      64'(port1_d),    64'd0);
    chk("rst_we",     64'(port1_we),   64'd0);
    chk("rst_loaded", 64'(bmp_loaded), 64'd0);
    chk("rst_error",  64'(bmp_error),  64'd0);
    chk("rst_width",  64'(bmp_width),  64'd0);
    chk("rst_height", 64'(bmp_height), 64'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // 1: valid 4x2, offset 54, ack 3 clk after each request
    ack_delay = 3;
    build_file(32, 4, 2, 16'd32, 54, 8'h42, 8'h4D, 8'h00);
    send_file(0, fbytes.size() - 1, 1'b1, 1'b1);
    wait_drain("t1_drain");
    check_stream("t1");
    if (got.size() == 32) begin
      chk("t1_first_a",  64'(got[0].a),   64'd0);
      chk("t1_first_ds", 64'(got[0].ds),  64'b01);
      chk("t1_last_a",   64'(got[31].a),  64'd15);
      chk("t1_last_ds",  64'(got[31].ds), 64'b10);
    end
    chk("t1_loaded", 64'(bmp_loaded), 64'd1);
    chk("t1_width",  64'(bmp_width),  64'd4);
    chk("t1_height", 64'(bmp_height), 64'd2);
    chk("t1_error",  64'(bmp_error),  64'd0);
    got.delete();

    // 2: bad signature
    build_file(8, 4, 2, 16'd32, 54, 8'h42, 8'h4E, 8'h00);
    send_file(0, fbytes.size() - 1, 1'b1, 1'b1);
    wait_drain("t2_drain");
    chk("t2_error",  64'(bmp_error),  64'd1);
    chk("t2_loaded", 64'(bmp_loaded), 64'd0);
    chk("t2_reqs",   64'(got.size()), 64'd0);
    got.delete();

    // 3: 24bpp rejected as soon as the last header byte is accepted
    build_file(8, 4, 2, 16'd24, 54, 8'h42, 8'h4D, 8'h00);
    send_file(0, 29, 1'b1, 1'b0);
    chk("t3_error_at29", 64'(bmp_error), 64'd3);
    send_file(30, fbytes.size() - 1, 1'b0, 1'b1);
    wait_drain("t3_drain");
    chk("t3_error",  64'(bmp_error),  64'd3);
    chk("t3_loaded", 64'(bmp_loaded), 64'd0);
    chk("t3_reqs",   64'(got.size()), 64'd0);
    got.delete();

    // 4: overflow with 1-clk strobes every 2 clk and a 40 clk ack
    hmin = 1; hmax = 1; lmin = 1; lmax = 1;
    ack_delay = 40;
    build_file(32, 4, 2, 16'd32, 54, 8'h42, 8'h4D, 8'h00);
    send_file(0, 58, 1'b1, 1'b0);
    chk("t4_no_err_5th", 64'(bmp_error), 64'd0);
    send_file(59, 59, 1'b0, 1'b0);
    @(negedge clk_sys);
    chk("t4_err_6th", 64'(bmp_error), 64'd5);
    send_file(60, fbytes.size() - 1, 1'b0, 1'b1);
    wait_drain("t4_drain");
    chk("t4_error",  64'(bmp_error),  64'd5);
    chk("t4_loaded", 64'(bmp_loaded), 64'd0);
    chk("t4_reqs",   64'(got.size()), 64'd1);
    if (got.size() > 0) chk("t4_first_a", 64'(got[0].a), 64'd0);
    got.delete();
    hmin = 1; hmax = 3; lmin = 6; lmax = 8;
    ack_delay = 3;

    // 5: truncated header, then a fresh valid download recovers
    build_file(16, 2, 2, 16'd32, 54, 8'h42, 8'h4D, 8'h00);
    send_file(0, 20, 1'b1, 1'b1);
    chk("t5_error",  64'(bmp_error),  64'd6);
    chk("t5_loaded", 64'(bmp_loaded), 64'd0);
    chk("t5_reqs",   64'(got.size()), 64'd0);
    w = $urandom_range(4, 1); h = $urandom_range(3, 1);
    build_file(w * h * 4, 32'(w), 32'(h), 16'd32, 54 + $urandom_range(6, 0), 8'h42, 8'h4D, 8'h00);
    send_file(0, fbytes.size() - 1, 1'b1, 1'b1);
    wait_drain("t5b_drain");
    chk("t5b_error",  64'(bmp_error),  64'd0);
    chk("t5b_loaded", 64'(bmp_loaded), 64'd1);
    chk("t5b_width",  64'(bmp_width),  64'(w));
    chk("t5b_height", 64'(bmp_height), 64'(h));
    check_stream("t5b");
    got.delete();

    // 6: reset in PIXELS with a request outstanding
    ack_delay = 30;
    build_file(32, 4, 2, 16'd32, 54, 8'h42, 8'h4D, 8'h00);
    send_file(0, 57, 1'b1, 1'b0);
    chk("t6_pending", 64'(port1_req != port1_ack), 64'd1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("t6_req_eq_ack", 64'(port1_req == port1_ack), 64'd1);
    chk("t6_we",     64'(port1_we),   64'd0);
    chk("t6_loaded", 64'(bmp_loaded), 64'd0);
    chk("t6_error",  64'(bmp_error),  64'd0);
    chk("t6_width",  64'(bmp_width),  64'd0);
    chk("t6_a",      64'(port1_a),    64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("t6_still_idle", 64'(port1_req == port1_ack), 64'd1);
    got.delete();

    // Randomized files: valid, bad offset or bad size, checked against the model
    for (int it = 0; it < 5; it++) begin
      ack_delay = $urandom_range(4, 1);
      kind = $urandom_range(3, 0);
      w = $urandom_range(4, 1); h = $urandom_range(3, 1);
      ofs = 54 + $urandom_range(6, 0);
      case (kind)
        2:       build_file(8, 32'(w), 32'(h), 16'd32, ($urandom_range(1, 0) != 0) ? 20 : ofs,
                            8'h42, 8'h4D, ($urandom_range(1, 0) != 0) ? 8'h01 : 8'h00);
        3:       build_file(8, ($urandom_range(1, 0) != 0) ? 32'd600 : 32'(w),
                            32'hFFFF_FFFE, 16'd32, ofs, 8'h42, 8'h4D, 8'h00);
        default: build_file(w * h * 4, 32'(w), 32'(h), 16'd32, ofs, 8'h42, 8'h4D, 8'h00);
      endcase
      e = exp_err();
      send_file(0, fbytes.size() - 1, 1'b1, 1'b1);
      wait_drain("rnd_drain");
      chk("rnd_error",  64'(bmp_error),  64'(e));
      chk("rnd_loaded", 64'(bmp_loaded), 64'(e == 3'd0));
      if (e == 3'd0) begin
        chk("rnd_width",  64'(bmp_width),  64'(w));
        chk("rnd_height", 64'(bmp_height), 64'(h));
        check_stream("rnd");
      end else begin
        chk("rnd_reqs", 64'(got.size()), 64'd0);
      end
      got.delete();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
